// File: rtl/wallace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wallace_pkg
// Description : Shared widths, partial-product array type and the column
//               occupancy masks that steer full/half-adder placement in
//               each Wallace layer of the 5x5 reduction tree.
// Revision    : 1.0 - initial release
// ============================================================================
package wallace_pkg;

    localparam int OP_W   = 5;
    localparam int PROD_W = 10;

    // pp[i][j] = a[j] & b[i], weight i+j
    typedef logic [OP_W-1:0][OP_W-1:0] pp_array_t;

    // Carry row occupancy: any column fed by two or more bits emits a carry
    // one column up.
    function automatic logic [PROD_W-1:0] carry_mask(
        input logic [PROD_W-1:0] m0,
        input logic [PROD_W-1:0] m1,
        input logic [PROD_W-1:0] m2
    );
        return ((m0 & m1) | (m0 & m2) | (m1 & m2)) << 1;
    endfunction

    // Partial-product row occupancy, row i covers columns i..i+4
    localparam logic [PROD_W-1:0] c_pp_m0 = 10'h01F;
    localparam logic [PROD_W-1:0] c_pp_m1 = 10'h03E;
    localparam logic [PROD_W-1:0] c_pp_m2 = 10'h07C;
    localparam logic [PROD_W-1:0] c_pp_m3 = 10'h0F8;
    localparam logic [PROD_W-1:0] c_pp_m4 = 10'h1F0;

    // Layer 2 inputs: layer-1 sum, layer-1 carry, pass-through pp row 3
    localparam logic [PROD_W-1:0] c_l2_m0 = c_pp_m0 | c_pp_m1 | c_pp_m2;
    localparam logic [PROD_W-1:0] c_l2_m1 = carry_mask(c_pp_m0, c_pp_m1, c_pp_m2);
    localparam logic [PROD_W-1:0] c_l2_m2 = c_pp_m3;

    // Layer 3 inputs: layer-2 sum, layer-2 carry, pass-through pp row 4
    localparam logic [PROD_W-1:0] c_l3_m0 = c_l2_m0 | c_l2_m1 | c_l2_m2;
    localparam logic [PROD_W-1:0] c_l3_m1 = carry_mask(c_l2_m0, c_l2_m1, c_l2_m2);
    localparam logic [PROD_W-1:0] c_l3_m2 = c_pp_m4;

    localparam int c_s1_rows = 4;

endpackage
`default_nettype wire

// File: rtl/wallace_fa.sv
`default_nettype none
// ============================================================================
// Module      : wallace_fa
// Description : Single-bit full adder. With HALF=1 the carry-in is forced low
//               so the cell behaves as a half adder.
// Revision    : 1.0 - initial release
// ============================================================================
module wallace_fa #(
    parameter bit HALF = 1'b0
) (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_co
);

    logic w_cin;

    assign w_cin = HALF ? 1'b0 : i_cin;
    assign o_s   = i_a ^ i_b ^ w_cin;
    assign o_co  = (i_a & i_b) | (w_cin & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/wallace_tree_reduction_5x5.sv
`default_nettype none
// ============================================================================
// Module      : wallace_tree_reduction_5x5
// Description : Two-stage pipelined 5x5 unsigned Wallace-tree reduction.
//               Produces sum row r1 and weighted carry row r2 with
//               r1 + r2 == a * b. No final carry-propagate adder.
// Revision    : 1.0 - initial release
// ============================================================================
module wallace_tree_reduction_5x5
    import wallace_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    output logic [PROD_W-1:0] r1,
    output logic [PROD_W-1:0] r2
);

    pp_array_t         w_pp;
    logic [PROD_W-1:0] w_pp_row [OP_W];
    logic [PROD_W-1:0] w_l1_s, w_l1_c;
    logic [PROD_W-1:0] w_l2_s, w_l2_c, w_l2_crow;
    logic [PROD_W-1:0] w_l3_s, w_l3_c;
    logic [PROD_W-1:0] r_s1_row [c_s1_rows];
    logic              r_s1_valid;

    // Partial products, each row zero-extended and shifted to its weight
    for (genvar i = 0; i < OP_W; i++) begin : g_pp_row
        for (genvar j = 0; j < OP_W; j++) begin : g_pp_bit
            assign w_pp[i][j] = a[j] & b[i];
        end
        assign w_pp_row[i] = PROD_W'(w_pp[i]) << i;
    end

    // Layer 1: pp rows 0..2 compressed; rows 3,4 pass to stage 1
    for (genvar k = 0; k < PROD_W; k++) begin : g_l1_col
        localparam int c_occ = int'(c_pp_m0[k]) + int'(c_pp_m1[k]) + int'(c_pp_m2[k]);
        if (c_occ == 3) begin : g_fa
            wallace_fa #(.HALF(1'b0)) u_fa (
                .i_a(w_pp_row[0][k]), .i_b(w_pp_row[1][k]), .i_cin(w_pp_row[2][k]),
                .o_s(w_l1_s[k]), .o_co(w_l1_c[k]));
        end else if (c_occ == 2) begin : g_ha
            wallace_fa #(.HALF(1'b1)) u_ha (
                .i_a(c_pp_m0[k] ? w_pp_row[0][k] : w_pp_row[1][k]),
                .i_b(c_pp_m2[k] ? w_pp_row[2][k] : w_pp_row[1][k]),
                .i_cin(1'b0), .o_s(w_l1_s[k]), .o_co(w_l1_c[k]));
        end else begin : g_pass
            // at most one bit present; absent bits are constant zero
            assign w_l1_s[k] = w_pp_row[0][k] | w_pp_row[1][k] | w_pp_row[2][k];
            assign w_l1_c[k] = 1'b0;
        end
    end

    // Stage 1: capture the four layer-1 rows and the valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            for (int i = 0; i < c_s1_rows; i++) begin
                r_s1_row[i] <= '0;
            end
        end else begin
            r_s1_valid  <= in_valid;
            r_s1_row[0] <= w_l1_s;
            r_s1_row[1] <= w_l1_c << 1;
            r_s1_row[2] <= w_pp_row[3];
            r_s1_row[3] <= w_pp_row[4];
        end
    end

    // Layer 2: stage-1 rows 0..2 compressed; row 3 passes to layer 3
    for (genvar k = 0; k < PROD_W; k++) begin : g_l2_col
        localparam int c_occ = int'(c_l2_m0[k]) + int'(c_l2_m1[k]) + int'(c_l2_m2[k]);
        if (c_occ == 3) begin : g_fa
            wallace_fa #(.HALF(1'b0)) u_fa (
                .i_a(r_s1_row[0][k]), .i_b(r_s1_row[1][k]), .i_cin(r_s1_row[2][k]),
                .o_s(w_l2_s[k]), .o_co(w_l2_c[k]));
        end else if (c_occ == 2) begin : g_ha
            wallace_fa #(.HALF(1'b1)) u_ha (
                .i_a(c_l2_m0[k] ? r_s1_row[0][k] : r_s1_row[1][k]),
                .i_b(c_l2_m2[k] ? r_s1_row[2][k] : r_s1_row[1][k]),
                .i_cin(1'b0), .o_s(w_l2_s[k]), .o_co(w_l2_c[k]));
        end else begin : g_pass
            assign w_l2_s[k] = r_s1_row[0][k] | r_s1_row[1][k] | r_s1_row[2][k];
            assign w_l2_c[k] = 1'b0;
        end
    end

    assign w_l2_crow = w_l2_c << 1;

    // Layer 3: final 3-to-2 compression into sum and carry rows
    for (genvar k = 0; k < PROD_W; k++) begin : g_l3_col
        localparam int c_occ = int'(c_l3_m0[k]) + int'(c_l3_m1[k]) + int'(c_l3_m2[k]);
        if (c_occ == 3) begin : g_fa
            wallace_fa #(.HALF(1'b0)) u_fa (
                .i_a(w_l2_s[k]), .i_b(w_l2_crow[k]), .i_cin(r_s1_row[3][k]),
                .o_s(w_l3_s[k]), .o_co(w_l3_c[k]));
        end else if (c_occ == 2) begin : g_ha
            wallace_fa #(.HALF(1'b1)) u_ha (
                .i_a(c_l3_m0[k] ? w_l2_s[k] : w_l2_crow[k]),
                .i_b(c_l3_m2[k] ? r_s1_row[3][k] : w_l2_crow[k]),
                .i_cin(1'b0), .o_s(w_l3_s[k]), .o_co(w_l3_c[k]));
        end else begin : g_pass
            assign w_l3_s[k] = w_l2_s[k] | w_l2_crow[k] | r_s1_row[3][k];
            assign w_l3_c[k] = 1'b0;
        end
    end

    // Stage 2: registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            r1        <= '0;
            r2        <= '0;
        end else begin
            out_valid <= r_s1_valid;
            r1        <= w_l3_s;
            r2        <= w_l3_c << 1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wallace_tree_reduction_5x5.sv
`default_nettype none
// ============================================================================
// Module      : tb_wallace_tree_reduction_5x5
// Description : Self-checking bench for the 5x5 Wallace reduction pipeline.
//               Expected rows come from a carry-save reference model and are
//               queued at drive time, then popped as results leave the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wallace_tree_reduction_5x5;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] a;
    logic [4:0] b;
    logic       out_valid;
    logic [9:0] r1;
    logic [9:0] r2;

    typedef struct {
        bit         v;
        int         prod;
        logic [9:0] e1;
        logic [9:0] e2;
    } item_t;

    item_t q_exp [$];
    int    n_total = 0;
    int    n_bad   = 0;

    wallace_tree_reduction_5x5 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .r1        (r1),
        .r2        (r2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // 3:2 carry-save step on whole rows; absent bits are zero
    function automatic void csa(input logic [9:0] p, input logic [9:0] q, input logic [9:0] r,
                                output logic [9:0] s, output logic [9:0] c);
        s = p ^ q ^ r;
        c = ((p & q) | (p & r) | (q & r)) << 1;
    endfunction

    function automatic void golden(input logic [4:0] x, input logic [4:0] y,
                                   output logic [9:0] s, output logic [9:0] c);
        logic [9:0] row [5];
        logic [9:0] s1, c1, s2, c2;
        for (int i = 0; i < 5; i++) row[i] = (y[i] ? {5'd0, x} : 10'd0) << i;
        csa(row[0], row[1], row[2], s1, c1);
        csa(s1, c1, row[3], s2, c2);
        csa(s2, c2, row[4], s, c);
    endfunction

    function automatic item_t make_item(input bit v, input logic [4:0] x, input logic [4:0] y);
        item_t it;
        it.v    = v;
        it.prod = int'(x) * int'(y);
        golden(x, y, it.e1, it.e2);
        return it;
    endfunction

    // Drive one cycle, then compare the result that left the pipe this edge
    task automatic step(input bit v, input logic [4:0] x, input logic [4:0] y);
        item_t it;
        in_valid = v;
        a        = x;
        b        = y;
        q_exp.push_back(make_item(v, x, y));
        @(posedge clk);
        #1;
        if (q_exp.size() >= 2) begin
            it = q_exp.pop_front();
            chk("out_valid", {31'd0, out_valid}, {31'd0, it.v});
            if (it.v) begin
                chk("sum", 32'(r1) + 32'(r2), it.prod);
                chk("r2_lsb", {31'd0, r2[0]}, 32'd0);
                chk("r1_msb", {31'd0, r1[9]}, 32'd0);
                chk("r1_row", {22'd0, r1}, {22'd0, it.e1});
                chk("r2_row", {22'd0, r2}, {22'd0, it.e2});
            end
        end
    endtask

    // After reset the output stage holds an empty slot
    task automatic flush_after_reset();
        q_exp.delete();
        q_exp.push_back(make_item(1'b0, 5'd0, 5'd0));
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_r1", {22'd0, r1}, 32'd0);
        chk("rst_r2", {22'd0, r2}, 32'd0);
        rst_n = 1'b1;
        flush_after_reset();

        // single product
        step(1'b1, 5'd5, 5'd3);
        step(1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 5'd0);

        // back-to-back stream
        step(1'b1, 5'd15, 5'd7);
        step(1'b1, 5'd31, 5'd31);
        step(1'b1, 5'd9, 5'd12);
        step(1'b0, 5'd0, 5'd0);

        // edge operands
        step(1'b1, 5'd0, 5'd0);
        step(1'b1, 5'd1, 5'd1);
        step(1'b1, 5'd31, 5'd1);
        step(1'b1, 5'd1, 5'd31);
        step(1'b0, 5'd0, 5'd0);

        // exhaustive sweep, one pair per cycle
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                step(1'b1, 5'(i), 5'(j));
            end
        end
        step(1'b0, 5'd0, 5'd0);

        // valid pattern 1,0,1 with the idle slot carrying live-looking data
        step(1'b1, 5'd6, 5'd7);
        step(1'b0, 5'd31, 5'd31);
        step(1'b1, 5'd3, 5'd11);
        step(1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 5'd0);

        // reset with two results in flight
        step(1'b1, 5'd31, 5'd31);
        step(1'b1, 5'd29, 5'd27);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_r1", {22'd0, r1}, 32'd0);
        chk("midrst_r2", {22'd0, r2}, 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        flush_after_reset();
        step(1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd13, 5'd17 - 5'd0);
        step(1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 5'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
